// File: rtl/ifu_fetch_if.sv
// Instruction-fetch SRAM-like bus between the IFU fetch master and the instruction memory slave.
// One 8-byte-aligned read per request; inst_rdata carries the word at addr in [31:0] and addr+4 in [63:32].
interface ifu_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch bus master: one 8B-aligned read per fetch, split into up to two instructions (optional perf counters under IFU_PERF_CNT_EN).
// Latency: ok pulses in the same cycle as inst_data_ok; minimum 2 cycles per fetch with a 0-wait slave.
// Backpressure: id_stall parks the beat in a buffer until decode frees up; flush discards in-flight or buffered data.
module ifu_fetch #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc,
    input  logic                  fetch_en,
    input  logic                  flush,
    input  logic                  id_stall,
    ifu_fetch_if.master           bus,
    output logic [31:0]           inst_rdata_1,
    output logic [31:0]           inst_rdata_2,
    output logic [31:0]           inst_pc_1,
    output logic                  inst_rdata_1_ok,
    output logic                  inst_rdata_2_ok
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_inst_cnt,
    output logic [PERF_CNT_W-1:0] perf_discard_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA,
        HOLD
    } state_t;

    state_t      state, state_nxt;
    logic        discard, discard_nxt;
    logic [31:0] req_pc;
    logic [31:0] hold_1, hold_2, hold_pc;
    logic        hold_ok2;

    logic        issue;
    logic        accept;
    logic        hold_fire;
    logic        deliver_now;
    logic [31:0] live_1, live_2;
    logic        live_ok2;

    // An odd-word PC only wants the upper half of the beat.
    assign live_ok2    = ~req_pc[2];
    assign live_1      = req_pc[2] ? bus.inst_rdata[63:32] : bus.inst_rdata[31:0];
    assign live_2      = req_pc[2] ? 32'h0 : bus.inst_rdata[63:32];
    assign deliver_now = accept & ~id_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            discard  <= 1'b0;
            req_pc   <= 32'h0;
            hold_1   <= 32'h0;
            hold_2   <= 32'h0;
            hold_pc  <= 32'h0;
            hold_ok2 <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            if (issue) begin
                req_pc <= pc;
            end
            // The last accepted beat doubles as the stall buffer and the held output value.
            if (accept) begin
                hold_1   <= live_1;
                hold_2   <= live_2;
                hold_pc  <= req_pc;
                hold_ok2 <= live_ok2;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        issue       = 1'b0;
        accept      = 1'b0;
        hold_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !flush) begin
                    issue     = 1'b1;
                    state_nxt = bus.inst_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                if (flush) begin
                    discard_nxt = 1'b1;
                end
                if (bus.inst_addr_ok) begin
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.inst_data_ok) begin
                    discard_nxt = 1'b0;
                    state_nxt   = IDLE;
                    if (!discard && !flush) begin
                        accept = 1'b1;
                        if (id_stall) begin
                            state_nxt = HOLD;
                        end
                    end
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (!id_stall) begin
                    hold_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.inst_req  = issue | (state == WAIT_ADDR);
    assign bus.inst_addr = {(issue ? pc[31:3] : req_pc[31:3]), 3'b000};

    assign inst_rdata_1    = accept ? live_1 : hold_1;
    assign inst_rdata_2    = accept ? live_2 : hold_2;
    assign inst_pc_1       = accept ? req_pc : hold_pc;
    assign inst_rdata_1_ok = deliver_now | hold_fire;
    assign inst_rdata_2_ok = (deliver_now & live_ok2) | (hold_fire & hold_ok2);

`ifdef IFU_PERF_CNT_EN
    logic drop;

    assign drop = ((state == WAIT_DATA) & bus.inst_data_ok & (discard | flush)) |
                  ((state == HOLD) & flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt    <= '0;
            perf_discard_cnt <= '0;
        end else begin
            perf_inst_cnt <= perf_inst_cnt + PERF_CNT_W'(inst_rdata_1_ok)
                                           + PERF_CNT_W'(inst_rdata_2_ok);
            if (drop) begin
                perf_discard_cnt <= perf_discard_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule
